and_serial_nbits: RTL and testbench



---
 rtl/and_serial_nbits.sv | 72 +++++++
 tb/tb_and_serial_nbits.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/and_serial_nbits.sv
// Serial AND reducer: takes an n-bit word on a start/ready handshake and ANDs it
// one bit per clock, LSB first. Optional macro AND_EARLY_EXIT_EN ends on the first zero bit.
module and_serial_nbits #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] X,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic         resultado
);

    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [n-1:0]    sh;
    logic            acc;
    logic [CW-1:0]   cnt;
    logic            acc_nxt;
    logic            last;

    // resultado must capture the value acc takes on the final shift edge
    assign acc_nxt = acc & sh[0];

`ifdef AND_EARLY_EXIT_EN
    assign last = (cnt == CW'(n - 1)) || !sh[0];
`else
    assign last = (cnt == CW'(n - 1));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sh        <= '0;
            acc       <= 1'b1;
            cnt       <= '0;
            resultado <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh    <= X;
                        acc   <= 1'b1;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= acc_nxt;
                    sh  <= sh >> 1;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        resultado <= acc_nxt;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state == SHIFT);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_and_serial_nbits.sv
// Bench for and_serial_nbits: n=4, n=1 and n=8 instances checked against a
// scoreboard of independently modelled results and latencies.
module tb_and_serial_nbits;

    logic       clk;
    logic       rst_n;
    logic [2:0] st, rdy, bsy, dn, res;
    logic [7:0] xv [3];
    int         cyc;
    int         nchk, nerr;

    typedef struct {
        logic r;
        int   lat;
    } exp_t;
    exp_t q[$];

    and_serial_nbits #(.n(4)) u4 (.clk(clk), .rst_n(rst_n), .start(st[0]), .X(xv[0][3:0]),
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .resultado(res[0]));
    and_serial_nbits #(.n(1)) u1 (.clk(clk), .rst_n(rst_n), .start(st[1]), .X(xv[1][0:0]),
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .resultado(res[1]));
    and_serial_nbits #(.n(8)) u8 (.clk(clk), .rst_n(rst_n), .start(st[2]), .X(xv[2]),
        .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .resultado(res[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic m_and(input logic [7:0] x, input int w);
        logic r;
        r = 1'b1;
        for (int i = 0; i < w; i++) r = r & x[i];
        return r;
    endfunction

    // edges from the accepting edge to the edge that enters DONE
    function automatic int m_lat(input logic [7:0] x, input int w);
`ifdef AND_EARLY_EXIT_EN
        for (int i = 0; i < w; i++) if (!x[i]) return i + 1;
`endif
        return (x[0] === 1'bx) ? 0 : w;
    endfunction

    // drives one accepted operand, then scrambles X and waits for done
    task automatic run(input int d, input logic [7:0] x, output bit to, output logic r, output int lat);
        int acc;
        to = 1'b1; r = 1'b0; lat = 0;
        @(negedge clk);
        for (int i = 0; i < 50 && !rdy[d]; i++) @(negedge clk);
        if (!rdy[d]) return;
        xv[d] = x;
        st[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc   = cyc;
        st[d] = 1'b0;
        xv[d] = 8'($urandom);
        for (int i = 0; i < 100; i++) begin
            if (dn[d]) begin
                to = 1'b0; r = res[d]; lat = cyc - acc;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nchk++; if (rdy !== 3'b111) begin nerr++; $display("FAIL reset_ready: got %b expected 111", rdy); end
        nchk++; if (bsy !== 3'b000) begin nerr++; $display("FAIL reset_busy: got %b expected 000", bsy); end
        nchk++; if (dn  !== 3'b000) begin nerr++; $display("FAIL reset_done: got %b expected 000", dn); end
        nchk++; if (res !== 3'b000) begin nerr++; $display("FAIL reset_resultado: got %b expected 000", res); end
        rst_n = 1'b1;
    endtask

    task automatic test_patterns();
        logic [7:0] pats [4];
        bit to; logic r; int lat; exp_t e;
        pats = '{8'h00, 8'h0A, 8'h0F, 8'h0B};
        foreach (pats[k]) begin
            q.push_back('{m_and(pats[k], 4), m_lat(pats[k], 4)});
            run(0, pats[k], to, r, lat);
            e = q.pop_front();
            nchk++;
            if (to) begin nerr++; $display("FAIL pat_timeout x=%h: no done", pats[k]); continue; end
            if (r !== e.r) begin nerr++; $display("FAIL pat_result x=%h: got %b expected %b", pats[k], r, e.r); end
            nchk++; if (lat !== e.lat) begin nerr++; $display("FAIL pat_latency x=%h: got %0d expected %0d", pats[k], lat, e.lat); end
            @(negedge clk);
            nchk++; if (dn[0] !== 1'b0) begin nerr++; $display("FAIL done_pulse x=%h: got %b expected 0", pats[k], dn[0]); end
            repeat (3) begin
                @(negedge clk);
                nchk++; if (res[0] !== e.r) begin nerr++; $display("FAIL result_hold x=%h: got %b expected %b", pats[k], res[0], e.r); end
            end
        end
    endtask

    task automatic test_abort();
        bit to; logic r; int lat; exp_t e; int ndone;
        q.push_back('{m_and(8'h0F, 4), m_lat(8'h0F, 4)});
        run(0, 8'h0F, to, r, lat);
        e = q.pop_front();
        nchk++; if (to || r !== e.r) begin nerr++; $display("FAIL abort_pre: got %b expected %b", r, e.r); end
        @(negedge clk);
        for (int i = 0; i < 20 && !rdy[0]; i++) @(negedge clk);
        xv[0] = 8'h0F; st[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        nchk++; if (bsy[0] !== 1'b1) begin nerr++; $display("FAIL abort_busy: got %b expected 1", bsy[0]); end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nchk++; if ({rdy[0], bsy[0], dn[0], res[0]} !== 4'b1000)
            begin nerr++; $display("FAIL abort_state: got %b expected 1000", {rdy[0], bsy[0], dn[0], res[0]}); end
        ndone = 0;
        repeat (10) begin @(negedge clk); if (dn[0]) ndone++; end
        nchk++; if (ndone !== 0) begin nerr++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [2];
        int acc_t [2];
        int na, nd, nbusy;
        exp_t e;
        vals = '{8'h0F, 8'h07};
        na = 0; nd = 0; nbusy = 0;
        @(negedge clk);
        for (int i = 0; i < 20 && !rdy[0]; i++) @(negedge clk);
        st[0] = 1'b1;
        for (int i = 0; i < 60 && nd < 2; i++) begin
            if (rdy[0] && na < 2) begin
                xv[0] = vals[na];
                q.push_back('{m_and(vals[na], 4), m_lat(vals[na], 4)});
                acc_t[na] = cyc + 1;
                na++;
            end
            if (bsy[0]) nbusy++;
            if (dn[0] && q.size() > 0) begin
                e = q.pop_front();
                nchk++; if (res[0] !== e.r) begin nerr++; $display("FAIL b2b_result%0d: got %b expected %b", nd, res[0], e.r); end
                nchk++; if (cyc - acc_t[nd] !== e.lat) begin nerr++; $display("FAIL b2b_latency%0d: got %0d expected %0d", nd, cyc - acc_t[nd], e.lat); end
                nd++;
            end
            if (nd < 2) @(negedge clk);
        end
        st[0] = 1'b0;
        nchk++; if (nd !== 2) begin nerr++; $display("FAIL b2b_timeout: got %0d dones expected 2", nd); end
        nchk++; if (acc_t[1] - acc_t[0] !== 6) begin nerr++; $display("FAIL b2b_spacing: got %0d expected 6", acc_t[1] - acc_t[0]); end
        nchk++; if (nbusy !== 8) begin nerr++; $display("FAIL b2b_busy_cycles: got %0d expected 8", nbusy); end
    endtask

    task automatic test_n1();
        logic [7:0] pats [2];
        bit to; logic r; int lat; exp_t e;
        pats = '{8'h01, 8'h00};
        foreach (pats[k]) begin
            q.push_back('{m_and(pats[k], 1), m_lat(pats[k], 1)});
            run(1, pats[k], to, r, lat);
            e = q.pop_front();
            nchk++;
            if (to) begin nerr++; $display("FAIL n1_timeout x=%h: no done", pats[k]); continue; end
            if (r !== e.r) begin nerr++; $display("FAIL n1_result x=%h: got %b expected %b", pats[k], r, e.r); end
            nchk++; if (lat !== e.lat) begin nerr++; $display("FAIL n1_latency x=%h: got %0d expected %0d", pats[k], lat, e.lat); end
        end
    endtask

    task automatic test_exhaustive_n8();
        bit to; logic r; int lat; exp_t e;
        for (int v = 0; v < 256; v++) begin
            q.push_back('{m_and(8'(v), 8), m_lat(8'(v), 8)});
            run(2, 8'(v), to, r, lat);
            e = q.pop_front();
            nchk++;
            if (to) begin nerr++; $display("FAIL n8_timeout x=%h: no done", v); continue; end
            if (r !== e.r || lat !== e.lat) begin
                nerr++;
                $display("FAIL n8_reduce x=%h: got r=%b lat=%0d expected r=%b lat=%0d", v, r, lat, e.r, e.lat);
            end
        end
    endtask

    initial begin
        cyc = 0; nchk = 0; nerr = 0;
        st = '0; rst_n = 1'b0;
        foreach (xv[i]) xv[i] = '0;
        test_reset();
        test_patterns();
        test_abort();
        test_back_to_back();
        test_n1();
        test_exhaustive_n8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
